// File: rtl/seven_seg_capture.sv
// seven_seg_capture: debounced 7-segment readback decoded into a show-ahead FIFO
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [6:0]                    seg_in,
  input  logic                          rd_en,
  output logic [4:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] SC = 4'(STABLE_CYCLES);
  logic [6:0]    seg_q, last_acc;
  logic [3:0]    run, run_nxt;
  logic          accept, push, pop, push_ok;
  logic [AW-1:0] wp, rp;
  logic [4:0]    mem [FIFO_DEPTH];
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction
  assign run_nxt = !ena ? 4'd0 : seg_in != seg_q ? 4'd1 : run == SC ? SC : run + 4'd1;
  assign accept  = run_nxt == SC && run != SC;
  assign push    = accept && seg_q != last_acc && seg_q != 7'h00;
  assign pop     = rd_en && !empty;
  assign push_ok = push && (!full || pop);
  assign empty   = count == CW'(0);
  assign full    = count == CW'(FIFO_DEPTH);
  assign rd_data = empty ? 5'h00 : mem[rp];
  // sample, run-length tracking, acceptance and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= 7'h00;
      run      <= 4'd0;
      last_acc <= 7'h00;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (ena) seg_q <= seg_in;
      run <= run_nxt;
      if (accept) last_acc <= seg_q;
      if (push_ok) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end
  // entry storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= decode(seg_q);
  end
endmodule
